// File: rtl/note_quantizer.sv
// Pitch measurement to debounced 6-bit note code ({1'b1, semitone from C4} or 0 for rest).
// Optional macro OCTAVE_FOLD_EN adds the FOLD state (up to 2 octave shifts into C4..A5).
module note_quantizer #(
    parameter int unsigned PERIOD_WIDTH = 20,
    parameter int unsigned STABLE_COUNT = 3,
    parameter logic [15:0] MAG_THRESH   = 16'd512
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    valid_in,
    input  logic [PERIOD_WIDTH-1:0] period_in,
    input  logic [15:0]             mag_in,
    output logic                    ready_out,
    output logic [5:0]              note_out,
    output logic                    note_change_out
);

`ifdef OCTAVE_FOLD_EN
    typedef enum logic [1:0] {IDLE, FOLD, SEARCH, DECIDE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEARCH, DECIDE} state_t;
`endif

    // Semitone boundaries: period for note k lies in (bound[k+1], bound[k]].
    function automatic logic [PERIOD_WIDTH-1:0] bound_lut(input logic [4:0] idx);
        logic [19:0] b;
        case (idx)
            5'd0:    b = 20'd292118;
            5'd1:    b = 20'd275723;
            5'd2:    b = 20'd260248;
            5'd3:    b = 20'd245641;
            5'd4:    b = 20'd231855;
            5'd5:    b = 20'd218842;
            5'd6:    b = 20'd206559;
            5'd7:    b = 20'd194966;
            5'd8:    b = 20'd184023;
            5'd9:    b = 20'd173695;
            5'd10:   b = 20'd163946;
            5'd11:   b = 20'd154744;
            5'd12:   b = 20'd146059;
            5'd13:   b = 20'd137862;
            5'd14:   b = 20'd130124;
            5'd15:   b = 20'd122821;
            5'd16:   b = 20'd115927;
            5'd17:   b = 20'd109421;
            5'd18:   b = 20'd103280;
            5'd19:   b = 20'd97483;
            5'd20:   b = 20'd92012;
            5'd21:   b = 20'd86847;
            5'd22:   b = 20'd81973;
            default: b = '0;
        endcase
        return PERIOD_WIDTH'(b);
    endfunction

    localparam logic [PERIOD_WIDTH-1:0] BOUND_TOP = bound_lut(5'd0);
    localparam logic [PERIOD_WIDTH-1:0] BOUND_BOT = bound_lut(5'd22);

    function automatic logic in_range(input logic [PERIOD_WIDTH-1:0] p);
        return (p > BOUND_BOT) && (p <= BOUND_TOP);
    endfunction

    state_t                  state_q, state_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [4:0]              k_q, k_d;
    logic [5:0]              class_q, class_d;
    logic [5:0]              cand_q, cand_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    commit_q, commit_d;
    logic [5:0]              note_q, note_d;
    logic                    pulse_q, pulse_d;
`ifdef OCTAVE_FOLD_EN
    logic [1:0]              fold_q, fold_d;
    logic [PERIOD_WIDTH-1:0] fold_shift;
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            period_q <= '0;
            k_q      <= '0;
            class_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            commit_q <= 1'b0;
            note_q   <= '0;
            pulse_q  <= 1'b0;
`ifdef OCTAVE_FOLD_EN
            fold_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            k_q      <= k_d;
            class_q  <= class_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            commit_q <= commit_d;
            note_q   <= note_d;
            pulse_q  <= pulse_d;
`ifdef OCTAVE_FOLD_EN
            fold_q   <= fold_d;
`endif
        end
    end

    // The debounce decision is registered in DECIDE and published one edge later,
    // so ready stays low through that publish cycle.
    assign ready_out       = (state_q == IDLE) && !commit_q;
    assign note_out        = note_q;
    assign note_change_out = pulse_q;

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        k_d      = k_q;
        class_d  = class_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        commit_d = 1'b0;
        note_d   = note_q;
        pulse_d  = 1'b0;
`ifdef OCTAVE_FOLD_EN
        fold_d     = fold_q;
        fold_shift = (period_q <= BOUND_BOT) ? (period_q << 1) : (period_q >> 1);
`endif

        if (commit_q && (cnt_q >= 4'(STABLE_COUNT)) && (cand_q != note_q)) begin
            note_d  = cand_q;
            pulse_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (valid_in && ready_out) begin
                    period_d = period_in;
                    k_d      = '0;
`ifdef OCTAVE_FOLD_EN
                    fold_d   = '0;
`endif
                    if (mag_in < MAG_THRESH) begin
                        class_d = '0;
                        state_d = DECIDE;
                    end else if (!in_range(period_in)) begin
`ifdef OCTAVE_FOLD_EN
                        state_d = FOLD;
`else
                        class_d = '0;
                        state_d = DECIDE;
`endif
                    end else begin
                        state_d = SEARCH;
                    end
                end
            end
`ifdef OCTAVE_FOLD_EN
            FOLD: begin
                period_d = fold_shift;
                fold_d   = fold_q + 2'd1;
                if (in_range(fold_shift)) begin
                    state_d = SEARCH;
                end else if (fold_q == 2'd1) begin
                    class_d = '0;
                    state_d = DECIDE;
                end
            end
`endif
            SEARCH: begin
                if (period_q > bound_lut(k_q + 5'd1)) begin
                    class_d = {1'b1, k_q};
                    state_d = DECIDE;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            DECIDE: begin
                if (class_q == cand_q) begin
                    cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
                end else begin
                    cand_d = class_q;
                    cnt_d  = 4'd1;
                end
                commit_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_note_quantizer.sv
// Directed vector bench for note_quantizer; expectations follow OCTAVE_FOLD_EN when defined.
`timescale 1ns/1ps
module tb_note_quantizer;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        valid_in = 1'b0;
    logic [19:0] period_in = '0;
    logic [15:0] mag_in = '0;
    logic        ready_out;
    logic [5:0]  note_out;
    logic        note_change_out;

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    note_quantizer #(
        .PERIOD_WIDTH(20),
        .STABLE_COUNT(3),
        .MAG_THRESH  (16'd512)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .valid_in       (valid_in),
        .period_in      (period_in),
        .mag_in         (mag_in),
        .ready_out      (ready_out),
        .note_out       (note_out),
        .note_change_out(note_change_out)
    );

    typedef struct {
        logic [19:0] period;
        logic [15:0] mag;
        int          lat;
        logic [5:0]  note;
        int          pulses;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic [19:0] p, input logic [15:0] m, input int lat,
                       input logic [5:0] note, input int pulses);
        vec_t v;
        v.period = p; v.mag = m; v.lat = lat; v.note = note; v.pulses = pulses;
        vecs.push_back(v);
    endtask

    // lat = edges after accept until ready_out returns; pulses counted up to one edge past that.
    task automatic send(input logic [19:0] p, input logic [15:0] m, output int lat, output int pulses);
        int w;
        lat = -1;
        pulses = 0;
        w = 0;
        @(negedge clk_in);
        while (!ready_out && w < 40) begin
            @(negedge clk_in);
            w++;
        end
        period_in = p;
        mag_in    = m;
        valid_in  = 1'b1;
        @(posedge clk_in);
        #1 valid_in = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk_in);
            #1;
            if (note_change_out) pulses++;
            if (ready_out) begin
                lat = c;
                break;
            end
        end
        @(posedge clk_in);
        #1;
        if (note_change_out) pulses++;
    endtask

    task automatic mid_search_reset(input int tag);
        int pulses;
        int w;
        pulses = 0;
        w = 0;
        @(negedge clk_in);
        while (!ready_out && w < 40) begin
            @(negedge clk_in);
            w++;
        end
        period_in = 20'd84375;
        mag_in    = 16'd1000;
        valid_in  = 1'b1;
        @(posedge clk_in);
        #1 valid_in = 1'b0;
        repeat (5) @(posedge clk_in);
        #1 rst_n_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_note", tag, int'(note_out), 0);
        check("rst_pulse", tag, int'(note_change_out), 0);
        check("rst_ready", tag, int'(ready_out), 1);
        rst_n_in = 1'b1;
        repeat (30) begin
            @(posedge clk_in);
            #1;
            if (note_change_out) pulses++;
        end
        check("rst_no_pulse", tag, pulses, 0);
        check("rst_note_after", tag, int'(note_out), 0);
        check("rst_ready_after", tag, int'(ready_out), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int pulses;

        rst_n_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check("reset_note", 0, int'(note_out), 0);
        check("reset_pulse", 0, int'(note_change_out), 0);
        check("reset_ready", 0, int'(ready_out), 1);
        rst_n_in = 1'b1;

        mid_search_reset(0);

        // C4 x3 then a held fourth, magnitude threshold edges.
        add(20'd283802, 16'd1000, 3, 6'b000000, 0);
        add(20'd283802, 16'd1000, 3, 6'b000000, 0);
        add(20'd283802, 16'd1000, 3, 6'b100000, 1);
        add(20'd283802, 16'd1000, 3, 6'b100000, 0);
        add(20'd283802, 16'd511,  2, 6'b100000, 0);
        add(20'd283802, 16'd512,  3, 6'b100000, 0);
        for (int i = 0; i < 5; i++) begin
            add(20'd252838, 16'd1000, 5, 6'b100000, 0);
            add(20'd225251, 16'd1000, 7, 6'b100000, 0);
        end
        add(20'd283802, 16'd100, 2, 6'b100000, 0);
        add(20'd283802, 16'd100, 2, 6'b100000, 0);
        add(20'd283802, 16'd100, 2, 6'b000000, 1);
        add(20'd283802, 16'd100, 2, 6'b000000, 0);
        add(20'd292118, 16'd1000, 3, 6'b000000, 0);
        add(20'd84375,  16'd1000, 24, 6'b000000, 0);
        add(20'd84375,  16'd1000, 24, 6'b000000, 0);
        add(20'd84375,  16'd1000, 24, 6'b110101, 1);
        add(20'd81974,  16'd1000, 24, 6'b110101, 0);
`ifdef OCTAVE_FOLD_EN
        add(20'd42188,  16'd1000, 25, 6'b110101, 0);
        add(20'd42188,  16'd1000, 25, 6'b110101, 0);
        add(20'd42188,  16'd1000, 25, 6'b110101, 0);
        add(20'd81973,  16'd1000, 14, 6'b110101, 0);
        add(20'd292119, 16'd1000, 16, 6'b110101, 0);
        add(20'd600000, 16'd1000, 16, 6'b110101, 0);
        add(20'd10000,  16'd1000, 4,  6'b110101, 0);
`else
        add(20'd42188,  16'd1000, 2, 6'b110101, 0);
        add(20'd42188,  16'd1000, 2, 6'b110101, 0);
        add(20'd42188,  16'd1000, 2, 6'b000000, 1);
        add(20'd81973,  16'd1000, 2, 6'b000000, 0);
        add(20'd292119, 16'd1000, 2, 6'b000000, 0);
        add(20'd600000, 16'd1000, 2, 6'b000000, 0);
        add(20'd10000,  16'd1000, 2, 6'b000000, 0);
`endif

        foreach (vecs[i]) begin
            send(vecs[i].period, vecs[i].mag, lat, pulses);
            check("latency", i, lat, vecs[i].lat);
            check("note", i, int'(note_out), int'(vecs[i].note));
            check("pulses", i, pulses, vecs[i].pulses);
        end

        mid_search_reset(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
